fifo_byte_packer: RTL and testbench
===================================

# fifo_byte_packer

Downstream consumer of the 8-bit synchronous FIFO. It pops bytes whenever the FIFO is non-empty and packs `BYTES` consecutive bytes, little-endian, into one wide word. Each word is presented on a valid/ready master port with a byte-keep mask, and a flush request emits a trailing partial word. It converts the FIFO's byte stream into the word-wide bus used by the next stage.

## Interface
- `DATA_W`, 8, width of one FIFO entry
- `BYTES`, 4, entries per output word (≥2)
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset; one clock; asynchronous, active-low
- `fifo_empty`  in  1  FIFO empty flag
- `fifo_data`  in  DATA_W  FIFO read data; valid the cycle after a pop
- `fifo_ren`  out  1  FIFO read enable; asserted only when `fifo_empty`=0
- `flush`  in  1  single-cycle request to emit any partial word
- `m_valid`  out  1  output word valid
- `m_ready`  in  1  downstream accepts word
- `m_data`  out  DATA_W*BYTES  packed word; byte k in bits [k*DATA_W +: DATA_W]
- `m_keep`  out  BYTES  byte k valid when bit k set
- `busy`  out  1  any byte held, in flight, or flush pending

## Operation
- State:
  - `asm_data`/`asm_cnt` (0..BYTES): assembly register and count
  - `rd_pend`: pop issued last cycle
  - `flush_req`: sticky flush
  - output register `m_*`
- Pop rule: `fifo_ren` = !`fifo_empty` && !`flush_req` && (`asm_cnt`+`rd_pend` < BYTES). The block never pops more than fits.
- Capture: when `rd_pend`=1, `fifo_data` is written to byte slot `asm_cnt`, and `asm_cnt` increments.
- Word completion: a capture that makes the count BYTES bypasses straight into the output register if it is free (!`m_valid` || `m_ready`). In that case `m_keep`=all ones and `asm_cnt`←0. Otherwise `asm_cnt`=BYTES holds the word until the output register frees, then transfers.
- Flush: `flush`=1 sets `flush_req`; further pops are blocked. Once `rd_pend`=0:
  - `asm_cnt`=0: `flush_req` clears, no output.
  - 0<`asm_cnt`<BYTES: when the output register is free, emit the word with `m_keep`=(1<<`asm_cnt`)-1 and unused bytes zero. `asm_cnt`←0, `flush_req` clears.
  - `asm_cnt`=BYTES: normal full transfer first, then `flush_req` clears.
- `flush` while `flush_req`=1 has no extra effect.
- Output handshake: `m_data`/`m_keep` are stable while `m_valid`=1 && `m_ready`=0. A new word may load in the same cycle the current one is accepted.
- `busy` = (`asm_cnt`≠0) || `rd_pend` || `flush_req` || `m_valid`.

## Timing
- Reset (async assert, sync release): `fifo_ren`=0 (gated during reset), `m_valid`=0, `m_data`=0, `m_keep`=0, `busy`=0; `asm_cnt`, `rd_pend`, `flush_req` cleared.
- Reset mid-operation drops any in-flight byte. The FIFO shares this reset.
- Latency: with the FIFO non-empty and `m_ready`=1, pops occur in cycles 0..BYTES-1. The pop in cycle BYTES is blocked. `m_valid`=1 in cycle BYTES+1.
- Sustained throughput: BYTES bytes per BYTES+1 cycles.
- `m_ready`=0 stalls: the assembly register fills to BYTES, then pops stop. Nothing is lost.
- `fifo_empty` rising mid-word: pops stop and the partial word waits, with no timeout.
- Flush in the same cycle as a pop: the pop completes and its byte is included in the partial word.

## Structure
- Package `fifo_pack_pkg`:
  - `keep_mask(cnt)` function
  - default `DATA_W`/`BYTES` localparams
  - count width `$clog2(BYTES+1)`
- Sub-module `fifo_pack_out_reg`: valid/ready output holding register, with load/accept and stall-stable data.
- Everything else lives in the top module.

## Test plan
- Push 8 bytes 0x01..0x08 with `m_ready`=1 → words 0x04030201, then 0x08070605. Both have `m_keep`=4'hF. The first `m_valid` comes 5 cycles after the first `fifo_ren`.
- Push 3 bytes 0xA1,0xA2,0xA3, then pulse `flush` → one word 0x00A3A2A1 with `m_keep`=4'h7, then `busy`=0.
- `flush` with the FIFO empty and nothing held → no `m_valid`; `flush_req` clears in 1 cycle.
- Push 12 bytes with `m_ready`=0 for 20 cycles → `m_valid`=1 with a stable first word. `fifo_ren` stops after 8 pops. Releasing `m_ready` yields 3 correct words in order.
- Drop `rst` while `asm_cnt`=2 and `m_valid`=1 → all outputs zero immediately. After release, new bytes 0x10..0x13 produce 0x13121110.
- FIFO emptying after every 1–2 pushes (random gaps) → no `fifo_ren` while `fifo_empty`=1, and the byte order is preserved.

Source files
------------

// File: rtl/fifo_pack_pkg.sv
// fifo_pack_pkg: shared defaults and the byte-keep mask helper for fifo_byte_packer
package fifo_pack_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int BYTES_DEF  = 4;
  localparam int CNT_W_DEF  = $clog2(BYTES_DEF + 1);
  function automatic logic [31:0] keep_mask(input int cnt);
    return (32'd1 << cnt) - 32'd1;
  endfunction
endpackage

// File: rtl/fifo_pack_out_reg.sv
// fifo_pack_out_reg: valid/ready holding register, contents frozen while stalled
module fifo_pack_out_reg #(
  parameter int W = 32,
  parameter int K = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic [K-1:0] i_keep,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic [K-1:0] o_keep,
  output logic         o_free
);
  assign o_free = !o_valid || i_ready;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_keep  <= '0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_data  <= i_data;
      o_keep  <= i_keep;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/fifo_byte_packer.sv
// fifo_byte_packer: pops bytes from a FIFO and packs them little-endian into
// BYTES-wide words on a valid/ready port, with flush for trailing partial words
module fifo_byte_packer
  import fifo_pack_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int BYTES  = BYTES_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_fifo_empty,
  input  logic [DATA_W-1:0]       i_fifo_data,
  output logic                    o_fifo_ren,
  input  logic                    i_flush,
  output logic                    o_m_valid,
  input  logic                    i_m_ready,
  output logic [DATA_W*BYTES-1:0] o_m_data,
  output logic [BYTES-1:0]        o_m_keep,
  output logic                    o_busy
);
  localparam int CW = $clog2(BYTES + 1);
  logic [DATA_W*BYTES-1:0] r_asm_data;
  logic [CW-1:0]           r_asm_cnt;
  logic                    r_rd_pend;
  logic                    r_flush_req;
  logic [DATA_W*BYTES-1:0] w_cap_data;
  logic [CW:0]             w_cnt_cap;
  logic [31:0]             w_mask;
  logic                    w_full;
  logic                    w_free;
  logic                    w_flush_emit;
  logic                    w_flush_clr;
  logic                    w_load;
  logic [BYTES-1:0]        w_load_keep;
  // count after this cycle's capture; one extra bit so the pop test cannot wrap
  assign w_cnt_cap    = {1'b0, r_asm_cnt} + (CW+1)'(r_rd_pend);
  assign w_full       = w_cnt_cap == (CW+1)'(BYTES);
  assign w_flush_emit = r_flush_req && !r_rd_pend && r_asm_cnt != '0 && !w_full && w_free;
  assign w_flush_clr  = r_flush_req && !r_rd_pend && (r_asm_cnt == '0 || w_flush_emit);
  assign w_load       = (w_full && w_free) || w_flush_emit;
  assign w_mask       = keep_mask(int'(r_asm_cnt));
  assign w_load_keep  = w_full ? '1 : w_mask[BYTES-1:0];
  assign o_fifo_ren   = i_rst_n && !i_fifo_empty && !r_flush_req && (w_cnt_cap < (CW+1)'(BYTES));
  assign o_busy       = r_asm_cnt != '0 || r_rd_pend || r_flush_req || o_m_valid;
  always_comb begin
    w_cap_data = r_asm_data;
    if (r_rd_pend) w_cap_data[r_asm_cnt*DATA_W +: DATA_W] = i_fifo_data;
  end
  // slots are cleared on every emission so unfilled bytes of a partial word read as zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_asm_data  <= '0;
      r_asm_cnt   <= '0;
      r_rd_pend   <= 1'b0;
      r_flush_req <= 1'b0;
    end else begin
      r_rd_pend   <= o_fifo_ren;
      r_flush_req <= r_flush_req ? !w_flush_clr : i_flush;
      r_asm_cnt   <= w_load ? '0 : w_cnt_cap[CW-1:0];
      r_asm_data  <= w_load ? '0 : w_cap_data;
    end
  end
  fifo_pack_out_reg #(.W(DATA_W*BYTES), .K(BYTES)) u_out (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_load),
    .i_data  (w_cap_data),
    .i_keep  (w_load_keep),
    .i_ready (i_m_ready),
    .o_valid (o_m_valid),
    .o_data  (o_m_data),
    .o_keep  (o_m_keep),
    .o_free  (w_free)
  );
endmodule

// File: tb/tb_fifo_byte_packer.sv
// tb_fifo_byte_packer: directed bench with a small byte-FIFO model and word monitor
module tb_fifo_byte_packer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_ren;
  logic        flush = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        busy;
  logic [7:0]  mem [0:255];
  int          wr_ptr = 0;
  int          rd_ptr;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          first_ren = -1;
  int          first_valid = -1;
  int          n_ren = 0;
  int          n_ren_empty = 0;
  int          n_unstable = 0;
  logic        prev_stall;
  logic [31:0] prev_d;
  logic [3:0]  prev_k;
  logic [31:0] got_d [$];
  logic [3:0]  got_k [$];

  fifo_byte_packer dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_fifo_empty (fifo_empty),
    .i_fifo_data  (fifo_data),
    .o_fifo_ren   (fifo_ren),
    .i_flush      (flush),
    .o_m_valid    (m_valid),
    .i_m_ready    (m_ready),
    .o_m_data     (m_data),
    .o_m_keep     (m_keep),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;
  assign fifo_empty = rd_ptr == wr_ptr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= wr_ptr;
      fifo_data <= '0;
    end else if (fifo_ren && !fifo_empty) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
      prev_d     <= '0;
      prev_k     <= '0;
    end else begin
      if (fifo_ren) n_ren <= n_ren + 1;
      if (fifo_ren && fifo_empty) n_ren_empty <= n_ren_empty + 1;
      if (fifo_ren && first_ren < 0) first_ren <= cyc;
      if (m_valid && first_valid < 0) first_valid <= cyc;
      if (prev_stall && (!m_valid || m_data !== prev_d || m_keep !== prev_k)) n_unstable <= n_unstable + 1;
      if (m_valid && m_ready) begin
        got_d.push_back(m_data);
        got_k.push_back(m_keep);
      end
      prev_stall <= m_valid && !m_ready;
      prev_d     <= m_data;
      prev_k     <= m_keep;
    end
    cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr++;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_words(input string tag, input int n);
    int t = 0;
    while (got_d.size() < n && t < 300) begin
      @(negedge clk);
      t++;
    end
    check(tag, 64'(got_d.size() >= n), 64'd1);
  endtask

  task automatic expect_word(input string tag, input logic [31:0] d, input logic [3:0] k);
    if (got_d.size() == 0) check({tag, "_missing"}, 64'd0, 64'd1);
    else begin
      check({tag, "_data"}, 64'(got_d.pop_front()), 64'(d));
      check({tag, "_keep"}, 64'(got_k.pop_front()), 64'(k));
    end
  endtask

  initial begin
    cycles(2);
    check("rst_ren", 64'(fifo_ren), 64'd0);
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_data", 64'(m_data), 64'd0);
    check("rst_keep", 64'(m_keep), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    cycles(2);

    for (int i = 1; i <= 8; i++) push(8'(i));
    wait_words("t1_words", 2);
    check("t1_latency", 64'(first_valid - first_ren), 64'd5);
    expect_word("t1_w0", 32'h04030201, 4'hF);
    expect_word("t1_w1", 32'h08070605, 4'hF);

    push(8'hA1); push(8'hA2); push(8'hA3);
    cycles(6);
    check("t2_no_early", 64'(got_d.size()), 64'd0);
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    wait_words("t2_words", 1);
    expect_word("t2_w", 32'h00A3A2A1, 4'h7);
    cycles(2);
    check("t2_busy", 64'(busy), 64'd0);

    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    check("t3_req", 64'(busy), 64'd1);
    cycles(1);
    check("t3_clear", 64'(busy), 64'd0);
    cycles(3);
    check("t3_no_word", 64'(got_d.size()), 64'd0);

    push(8'h55); push(8'h66);
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    wait_words("t4_words", 1);
    expect_word("t4_w", 32'h00000055, 4'h1);
    cycles(4);
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    wait_words("t4b_words", 1);
    expect_word("t4b_w", 32'h00000066, 4'h1);
    cycles(3);

    m_ready = 1'b0;
    n_ren = 0;
    for (int i = 0; i < 12; i++) push(8'(8'h21 + i));
    cycles(20);
    check("t5_valid", 64'(m_valid), 64'd1);
    check("t5_held", 64'(m_data), 64'h24232221);
    check("t5_pops", 64'(n_ren), 64'd8);
    check("t5_stable", 64'(n_unstable), 64'd0);
    m_ready = 1'b1;
    wait_words("t5_words", 3);
    expect_word("t5_w0", 32'h24232221, 4'hF);
    expect_word("t5_w1", 32'h28272625, 4'hF);
    expect_word("t5_w2", 32'h2C2B2A29, 4'hF);

    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'(8'h31 + i));
    cycles(12);
    check("t6_pre_valid", 64'(m_valid), 64'd1);
    check("t6_pre_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid", 64'(m_valid), 64'd0);
    check("t6_data", 64'(m_data), 64'd0);
    check("t6_keep", 64'(m_keep), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_ren", 64'(fifo_ren), 64'd0);
    cycles(2);
    rst_n = 1'b1;
    m_ready = 1'b1;
    got_d.delete();
    got_k.delete();
    cycles(1);
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
    wait_words("t6_words", 1);
    expect_word("t6_w", 32'h13121110, 4'hF);

    begin
      int sent = 0;
      while (sent < 16) begin
        int n = (sent == 15) ? 1 : int'($urandom_range(1, 2));
        for (int j = 0; j < n; j++) push(8'(8'h80 + sent + j));
        sent += n;
        for (int t = 0; t < 20 && !fifo_empty; t++) cycles(1);
        cycles(1 + int'($urandom_range(0, 3)));
      end
    end
    wait_words("t7_words", 4);
    expect_word("t7_w0", 32'h83828180, 4'hF);
    expect_word("t7_w1", 32'h87868584, 4'hF);
    expect_word("t7_w2", 32'h8B8A8988, 4'hF);
    expect_word("t7_w3", 32'h8F8E8D8C, 4'hF);
    check("ren_when_empty", 64'(n_ren_empty), 64'd0);
    check("stall_stable", 64'(n_unstable), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
